// File: rtl/io_cond_pkg.sv
// Shared constants and types for the board-input conditioner.
package io_cond_pkg;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 4;

  localparam int DB_COUNT_DEFAULT = 250000;
  localparam int CNT_W_DEFAULT    = 18;

  // Field positions of the press flags inside the I/O-mapped button status word.
  localparam int EVENTS_BIT_LSB  = 0;
  localparam int OVERRUN_BIT_LSB = EVENTS_BIT_LSB + NUM_BTN;

  typedef logic [NUM_BTN-1:0] btn_vec_t;
  typedef logic [NUM_SW-1:0]  sw_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, then a level that only changes after
// DB_COUNT consecutive cycles of disagreement with the synchronised input.
module debounce_bit #(
  parameter int DB_COUNT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw switches/buttons and keeps sticky press/overrun flags.
// Define IOC_SWITCH_DEBOUNCE_EN to debounce switches as well as buttons.
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  switches_raw,
  input  logic [NUM_BTN-1:0] buttons_raw,
  input  logic [NUM_BTN-1:0] clr_events,
  output logic [NUM_SW-1:0]  switches,
  output logic [NUM_BTN-1:0] buttons,
  output logic [NUM_BTN-1:0] btn_events,
  output logic [NUM_BTN-1:0] btn_overrun,
  output logic               event_any
);

  btn_vec_t btn_prev;
  btn_vec_t rise;
  btn_vec_t events_next;
  btn_vec_t overrun_next;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (buttons_raw[i]),
      .level (buttons[i])
    );
  end

`ifdef IOC_SWITCH_DEBOUNCE_EN
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (switches_raw[i]),
      .level (switches[i])
    );
  end
`else
  sw_vec_t sw_sync1;
  sw_vec_t sw_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= switches_raw;
      sw_sync2 <= sw_sync1;
    end
  end

  assign switches = sw_sync2;
`endif

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  // A press coinciding with its clear wins: the event is kept, overrun is not.
  always_comb begin
    rise         = buttons & ~btn_prev;
    events_next  = rise | (btn_events & ~clr_events);
    overrun_next = (rise & btn_events & ~clr_events) | (btn_overrun & ~clr_events);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev    <= '0;
      btn_events  <= '0;
      btn_overrun <= '0;
      event_any   <= 1'b0;
    end else begin
      btn_prev    <= buttons;
      btn_events  <= events_next;
      btn_overrun <= overrun_next;
      event_any   <= |events_next;
    end
  end

endmodule
